conditional_3d_array_row_sequencer: RTL and testbench
=====================================================

Name: conditional_3d_array_row_sequencer

Overview:
Sequences one conditional select job over a ROWS x COLS x BIT_WIDTH array, one row per beat. It accepts a job (a condition bit) on a start handshake and drives a row index to two external row sources (if_true, if_false). It streams the selected row out through a registered valid/ready stage and pulses done when the last row has been accepted. It sits between row-addressable array storage and a downstream row consumer, replacing the all-at-once combinational select when array width is too large.

Parameters:
BIT_WIDTH, 4, element width in bits
ROWS, 8, rows per array (>=1)
COLS, 8, elements per row (>=1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  job request
start_ready  output  1  high only in IDLE
start_condition  input  1  1 selects if_true rows, 0 selects if_false; sampled only at start handshake
row_idx  output  ROW_IDX_W  row currently fetched; ROW_IDX_W = max(1, clog2(ROWS))
if_true_row  input  COLS*BIT_WIDTH  same-cycle (combinational) read of if_true[row_idx]
if_false_row  input  COLS*BIT_WIDTH  same-cycle read of if_false[row_idx]
out_valid  output  1  out_row holds a valid row
out_ready  input  1  consumer accepts the row
out_row  output  COLS*BIT_WIDTH  selected row; element c at bits [c*BIT_WIDTH +: BIT_WIDTH]
out_row_idx  output  ROW_IDX_W  index of out_row
out_last  output  1  out_row is row ROWS-1
busy  output  1  state != IDLE
done  output  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Clock and reset (decided): one clock, clk; reset rst_n is asynchronous, active-low. All flops clear immediately on rst_n low, including mid-job. The job is discarded and no done pulse occurs.
- Reset values: state=IDLE, start_ready=1, out_valid=0, out_row=0, out_row_idx=0, out_last=0, row_idx=0, busy=0, done=0.
- States: IDLE, RUN, DONE.
- IDLE: start_ready=1. On start_valid&start_ready, latch start_condition into cond_q, clear fetch counter rd_q, and go to RUN. The rd_q counter is clog2(ROWS+1) bits wide.
- RUN: load = !out_valid | out_ready.
  - If load and rd_q<ROWS: out_row <= cond_q ? if_true_row : if_false_row; out_row_idx <= rd_q; out_last <= (rd_q==ROWS-1); out_valid <= 1; rd_q++.
  - If load and rd_q==ROWS: out_valid <= 0.
  - out_valid, out_row, out_row_idx and out_last hold stable while out_valid & !out_ready.
  - On out_valid & out_ready & out_last: go to DONE.
- row_idx = rd_q[ROW_IDX_W-1:0] while rd_q<ROWS, else ROWS-1.
- DONE: one cycle, done=1, start_ready=0, then IDLE.
- Timing, with the start handshake at cycle T and out_ready held high:
  - first out_valid at T+2; rows 0..ROWS-1 on consecutive cycles;
  - last handshake at T+ROWS+1;
  - done at T+ROWS+2;
  - start_ready at T+ROWS+3.
- Throughput: 1 row/cycle with no bubbles under continuous out_ready.
- start_condition changes after the start handshake are ignored for the rest of the job.
- ROWS=1: a single beat with out_last=1 and out_row_idx=0.

Optional Feature:
Macro CONDITIONAL_3D_ARRAY_SEQ_ABORT_EN.
- With the macro: adds input abort (1) and output aborted (1).
  - abort high in RUN: next cycle out_valid=0, state=IDLE, aborted=1 for one cycle, no done pulse.
  - abort is ignored in IDLE and DONE.
  - abort and the last handshake in the same cycle: the handshake is completed, the job is treated as aborted, and no done pulse occurs.
- Without the macro: no abort or aborted ports; every job runs to completion.

Decomposition:
- Package conditional_3d_array_pkg holds the state enum (IDLE, RUN, DONE) and a row_idx_width(ROWS) function returning max(1, clog2(ROWS)).
- One natural sub-module: conditional_row_register, the registered valid/ready output stage with 2:1 row mux, load enable, and out_last/out_row_idx capture.
- The FSM and counter stay in the top module.

Test Plan:
- Reset, then condition=1, out_ready=1, ROWS=8, if_true[r] all elements = r, if_false all 0xF → rows 0..7 with out_row elements = r on cycles T+2..T+9, out_last only on row 7, done at T+10.
- Condition=0, same data → all out_row elements = 0xF; start_condition toggled mid-job → no effect.
- out_ready low for 3 cycles while row 3 is valid → out_row/out_row_idx=3 held stable, row 4 follows with no row skipped or duplicated.
- start_valid held high during a job → start_ready=0 until T+11; second job accepted at T+11.
- rst_n pulsed low at row 4 → outputs return to reset values asynchronously, no done pulse; a new job restarts at row 0.
- With CONDITIONAL_3D_ARRAY_SEQ_ABORT_EN: abort at row 2 → aborted pulse, no done, IDLE next cycle; abort together with the last handshake → aborted, no done.

Source files
------------

// File: rtl/conditional_3d_array_pkg.sv
// Shared types and helpers for the conditional 3-D array row sequencer.
package conditional_3d_array_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    function automatic int row_idx_width(input int rows);
        return (rows <= 1) ? 1 : $clog2(rows);
    endfunction

endpackage

// File: rtl/conditional_row_register.sv
// Registered valid/ready output stage: captures the selected row, its index and
// the last-row flag whenever the stage is empty or being drained.
module conditional_row_register #(
    parameter int BIT_WIDTH = 4,
    parameter int COLS      = 8,
    parameter int IDX_W     = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      load,
    input  logic                      fill,
    input  logic                      cond,
    input  logic [COLS*BIT_WIDTH-1:0] true_row,
    input  logic [COLS*BIT_WIDTH-1:0] false_row,
    input  logic [IDX_W-1:0]          idx,
    input  logic                      last,
    output logic                      out_valid,
    output logic [COLS*BIT_WIDTH-1:0] out_row,
    output logic [IDX_W-1:0]          out_row_idx,
    output logic                      out_last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_row     <= '0;
            out_row_idx <= '0;
            out_last    <= 1'b0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (load) begin
            // With no rows left to fetch, a drained stage simply goes empty.
            if (fill) begin
                out_row     <= cond ? true_row : false_row;
                out_row_idx <= idx;
                out_last    <= last;
                out_valid   <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/conditional_3d_array_row_sequencer.sv
// Streams one conditionally selected array, one row per beat, to a valid/ready consumer.
// Optional abort input/aborted output enabled by CONDITIONAL_3D_ARRAY_SEQ_ABORT_EN.
module conditional_3d_array_row_sequencer
    import conditional_3d_array_pkg::*;
#(
    parameter int BIT_WIDTH = 4,
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    localparam int ROW_IDX_W = row_idx_width(ROWS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_valid,
    output logic                      start_ready,
    input  logic                      start_condition,
    output logic [ROW_IDX_W-1:0]      row_idx,
    input  logic [COLS*BIT_WIDTH-1:0] if_true_row,
    input  logic [COLS*BIT_WIDTH-1:0] if_false_row,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [COLS*BIT_WIDTH-1:0] out_row,
    output logic [ROW_IDX_W-1:0]      out_row_idx,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
`ifdef CONDITIONAL_3D_ARRAY_SEQ_ABORT_EN
    ,
    input  logic                      abort,
    output logic                      aborted
`endif
);

    localparam int CNT_W = $clog2(ROWS + 1);
    localparam logic [CNT_W-1:0]     ROWS_C   = CNT_W'(ROWS);
    localparam logic [CNT_W-1:0]     LAST_C   = CNT_W'(ROWS - 1);
    localparam logic [ROW_IDX_W-1:0] LAST_IDX = ROW_IDX_W'(ROWS - 1);

    seq_state_t     state;
    seq_state_t     state_next;
    logic           cond_q;
    logic [CNT_W-1:0] rd_q;
    logic           fill;
    logic           load;
    logic           last_hs;
    logic           kill;

    assign fill    = (rd_q < ROWS_C);
    assign load    = (state == RUN) && (!out_valid || out_ready);
    assign last_hs = (state == RUN) && out_valid && out_ready && out_last;
    assign row_idx = fill ? rd_q[ROW_IDX_W-1:0] : LAST_IDX;

`ifdef CONDITIONAL_3D_ARRAY_SEQ_ABORT_EN
    assign kill = (state == RUN) && abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aborted <= 1'b0;
        end else begin
            aborted <= kill;
        end
    end
`else
    assign kill = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        start_ready = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                if (start_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // Abort wins over a coinciding final handshake, so no done pulse follows.
                if (kill) begin
                    state_next = IDLE;
                end else if (last_hs) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cond_q <= 1'b0;
            rd_q   <= '0;
        end else if (state == IDLE && start_valid) begin
            cond_q <= start_condition;
            rd_q   <= '0;
        end else if (load && fill) begin
            rd_q <= rd_q + CNT_W'(1);
        end
    end

    conditional_row_register #(
        .BIT_WIDTH (BIT_WIDTH),
        .COLS      (COLS),
        .IDX_W     (ROW_IDX_W)
    ) u_row_register (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (kill),
        .load        (load),
        .fill        (fill),
        .cond        (cond_q),
        .true_row    (if_true_row),
        .false_row   (if_false_row),
        .idx         (rd_q[ROW_IDX_W-1:0]),
        .last        (rd_q == LAST_C),
        .out_valid   (out_valid),
        .out_row     (out_row),
        .out_row_idx (out_row_idx),
        .out_last    (out_last)
    );

endmodule

// File: tb/tb_conditional_3d_array_row_sequencer.sv
// Self-checking bench for conditional_3d_array_row_sequencer against a row-stream reference model.
`timescale 1ns/1ps
module tb_conditional_3d_array_row_sequencer;

    localparam int BIT_WIDTH = 4;
    localparam int ROWS      = 8;
    localparam int COLS      = 8;
    localparam int IDX_W     = (ROWS <= 1) ? 1 : $clog2(ROWS);
    localparam int RW        = COLS * BIT_WIDTH;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start_valid = 1'b0;
    logic             start_condition = 1'b0;
    logic             out_ready = 1'b0;
    logic             start_ready;
    logic [IDX_W-1:0] row_idx;
    logic [RW-1:0]    if_true_row;
    logic [RW-1:0]    if_false_row;
    logic             out_valid;
    logic [RW-1:0]    out_row;
    logic [IDX_W-1:0] out_row_idx;
    logic             out_last;
    logic             busy;
    logic             done;
`ifdef CONDITIONAL_3D_ARRAY_SEQ_ABORT_EN
    logic             abort = 1'b0;
    logic             aborted;
`endif

    logic [RW-1:0] mem_true  [ROWS];
    logic [RW-1:0] mem_false [ROWS];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        if_true_row  = mem_true[row_idx];
        if_false_row = mem_false[row_idx];
    end

    conditional_3d_array_row_sequencer #(
        .BIT_WIDTH (BIT_WIDTH),
        .ROWS      (ROWS),
        .COLS      (COLS)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_valid     (start_valid),
        .start_ready     (start_ready),
        .start_condition (start_condition),
        .row_idx         (row_idx),
        .if_true_row     (if_true_row),
        .if_false_row    (if_false_row),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_row         (out_row),
        .out_row_idx     (out_row_idx),
        .out_last        (out_last),
        .busy            (busy),
        .done            (done)
`ifdef CONDITIONAL_3D_ARRAY_SEQ_ABORT_EN
        ,
        .abort           (abort),
        .aborted         (aborted)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_out_row"}, 64'(out_row), 64'(0));
        chk({tag, "_out_row_idx"}, 64'(out_row_idx), 64'(0));
        chk({tag, "_out_last"}, 64'(out_last), 64'(0));
        chk({tag, "_row_idx"}, 64'(row_idx), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_start_ready"}, 64'(start_ready), 64'(1));
    endtask

    // mode 0: out_ready always high (cycle-exact timing checked)
    // mode 1: random out_ready;  mode 2: 3-cycle stall while row 3 is presented
    task automatic do_job(input logic c, input int mode, input bit keep_start);
        int exp_idx;
        int t;
        int phase;
        int stall;
        int ri;
        logic [RW-1:0] exp_row;
        chk("idle_start_ready", 64'(start_ready), 64'(1));
        start_valid     = 1'b1;
        start_condition = c;
        out_ready       = 1'b1;
        step();
        start_valid     = keep_start;
        start_condition = ~c;
        exp_idx = 0;
        phase   = 0;
        stall   = 0;
        t       = 1;
        while (phase != 3) begin
            if (t > 200) begin
                chk("job_timeout", 64'(0), 64'(1));
                phase = 3;
            end else begin
                case (phase)
                    0: begin
                        chk("run_busy", 64'(busy), 64'(1));
                        chk("run_start_ready", 64'(start_ready), 64'(0));
                        chk("run_done", 64'(done), 64'(0));
                        chk("run_out_valid", 64'(out_valid), 64'(t >= 2 && exp_idx < ROWS));
                        ri = (t < 2) ? 0 : exp_idx + 1;
                        if (ri > ROWS - 1) ri = ROWS - 1;
                        chk("row_idx", 64'(row_idx), 64'(ri));
                        if (t >= 2) begin
                            exp_row = c ? mem_true[exp_idx] : mem_false[exp_idx];
                            chk("out_row_idx", 64'(out_row_idx), 64'(exp_idx));
                            chk("out_row", 64'(out_row), 64'(exp_row));
                            chk("out_last", 64'(out_last), 64'(exp_idx == ROWS - 1));
                            case (mode)
                                1: out_ready = 1'($urandom_range(0, 1));
                                2: begin
                                    if (exp_idx == 3 && stall < 3) begin
                                        out_ready = 1'b0;
                                        stall++;
                                    end else begin
                                        out_ready = 1'b1;
                                    end
                                end
                                default: out_ready = 1'b1;
                            endcase
                            if (out_ready) begin
                                if (exp_idx == ROWS - 1) begin
                                    phase = 1;
                                    if (mode == 0) chk("last_hs_time", 64'(t), 64'(ROWS + 1));
                                end
                                exp_idx++;
                            end
                        end
                    end
                    1: begin
                        chk("done_pulse", 64'(done), 64'(1));
                        chk("done_busy", 64'(busy), 64'(1));
                        chk("done_start_ready", 64'(start_ready), 64'(0));
                        chk("done_out_valid", 64'(out_valid), 64'(0));
                        if (mode == 0) chk("done_time", 64'(t), 64'(ROWS + 2));
                        phase = 2;
                    end
                    default: begin
                        chk("end_done", 64'(done), 64'(0));
                        chk("end_busy", 64'(busy), 64'(0));
                        chk("end_start_ready", 64'(start_ready), 64'(1));
                        if (mode == 0) chk("ready_time", 64'(t), 64'(ROWS + 3));
                        phase = 3;
                    end
                endcase
                if (phase != 3) begin
                    step();
                    t++;
                end
            end
        end
    endtask

`ifdef CONDITIONAL_3D_ARRAY_SEQ_ABORT_EN
    task automatic do_abort(input int at_row);
        int guard;
        guard = 0;
        start_valid     = 1'b1;
        start_condition = 1'b1;
        out_ready       = 1'b1;
        step();
        start_valid = 1'b0;
        while (!(out_valid && int'(out_row_idx) == at_row) && guard < 50) begin
            step();
            guard++;
        end
        chk("abort_reach_row", 64'(out_row_idx), 64'(at_row));
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("aborted_pulse", 64'(aborted), 64'(1));
        chk("abort_out_valid", 64'(out_valid), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_start_ready", 64'(start_ready), 64'(1));
        chk("abort_no_done", 64'(done), 64'(0));
        step();
        chk("aborted_clears", 64'(aborted), 64'(0));
        chk("abort_no_done_late", 64'(done), 64'(0));
    endtask
`endif

    initial begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                mem_true[r][c*BIT_WIDTH +: BIT_WIDTH] = BIT_WIDTH'(r);
            end
            mem_false[r] = '1;
        end

        #2 rst_n = 1'b0;
        #1 check_idle_outputs("reset");
        step();
        step();
        rst_n = 1'b1;
        step();
        check_idle_outputs("post_reset");

        // Directed pattern: condition true, then false with the condition toggled mid-job.
        do_job(1'b1, 0, 1'b0);
        do_job(1'b0, 0, 1'b0);

        // Back-pressure while row 3 is presented.
        do_job(1'b1, 2, 1'b0);

        // start_valid held through a job: next job accepted right after DONE.
        do_job(1'b0, 0, 1'b1);
        do_job(1'b1, 0, 1'b0);

        // Asynchronous reset in the middle of a job.
        start_valid     = 1'b1;
        start_condition = 1'b1;
        out_ready       = 1'b1;
        step();
        start_valid = 1'b0;
        repeat (5) step();
        chk("pre_reset_row", 64'(out_row_idx), 64'(4));
        rst_n = 1'b0;
        #1 check_idle_outputs("mid_reset");
        step();
        step();
        rst_n = 1'b1;
        repeat (3) begin
            step();
            chk("reset_no_done", 64'(done), 64'(0));
            chk("reset_idle_busy", 64'(busy), 64'(0));
        end
        do_job(1'b0, 0, 1'b0);

        // Randomized data, condition and back-pressure.
        repeat (4) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    mem_true[r][c*BIT_WIDTH +: BIT_WIDTH]  = BIT_WIDTH'($urandom);
                    mem_false[r][c*BIT_WIDTH +: BIT_WIDTH] = BIT_WIDTH'($urandom);
                end
            end
            do_job(1'($urandom_range(0, 1)), 1, 1'b0);
            repeat ($urandom_range(0, 2)) step();
        end

`ifdef CONDITIONAL_3D_ARRAY_SEQ_ABORT_EN
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_idle_ignored", 64'(aborted), 64'(0));
        chk("abort_idle_busy", 64'(busy), 64'(0));
        do_abort(2);
        do_abort(ROWS - 1);
        do_job(1'b1, 0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
